// File: rtl/fourier_seq_ctrl.sv
// fourier_seq_ctrl: frame sequencer for the fourier_srg DFT core.
// Loads an N-sample frame into the core from a valid/ready stream, runs the
// transform with a timeout, then streams the N complex bins out through a
// 2-entry skid FIFO that supports back-to-back reads at one result per cycle.
// Optional build macro: FOURIER_SEQ_PERF_EN adds a frame latency counter on
// perf_cycles; without it perf_cycles is tied to zero.
module fourier_seq_ctrl #(
  parameter int N       = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [7:0]        out_index,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        core_operation,
  output logic [31:0]       core_addr,
  output logic [DATA_W-1:0] core_x,
  input  logic [DATA_W-1:0] core_y_re,
  input  logic [DATA_W-1:0] core_y_im,
  input  logic              core_done,
  output logic              busy,
  output logic              error,
  output logic [31:0]       perf_cycles
);

  localparam logic [7:0]  LAST_IDX = 8'(N - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PROC, READ, ERR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_load_cnt;
  logic [7:0]        r_rd_cnt;
  logic [7:0]        r_cap_idx;
  logic              r_rd_done;
  logic              r_inflight;
  logic [31:0]       r_to_cnt;
  logic [1:0]        r_occ;
  logic              r_rptr;
  logic              r_wptr;
  logic [DATA_W-1:0] r_fre  [2];
  logic [DATA_W-1:0] r_fim  [2];
  logic [7:0]        r_fidx [2];

  logic              w_in_ready;
  logic              w_beat;
  logic              w_out_valid;
  logic              w_pop;
  logic              w_last_pop;
  logic [1:0]        w_pend;
  logic              w_issue;

  // Handshake and read-issue qualifiers shared by the FSM and the datapath
  assign w_in_ready  = reset && !abort && ((r_state == IDLE) || (r_state == LOAD));
  assign w_beat      = in_valid && w_in_ready;
  assign w_out_valid = (r_occ != 2'd0);
  assign w_pop       = w_out_valid && out_ready && !abort;
  assign w_last_pop  = w_pop && (r_fidx[r_rptr] == LAST_IDX);
  // Occupancy after this cycle's pop plus the read still in flight; keeps the
  // FIFO from overflowing while allowing one new read per cycle
  assign w_pend      = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue     = (r_state == READ) && !abort && !r_rd_done && (w_pend < 2'd2);

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_re    = w_out_valid ? r_fre[r_rptr]  : '0;
  assign out_im    = w_out_valid ? r_fim[r_rptr]  : '0;
  assign out_index = w_out_valid ? r_fidx[r_rptr] : '0;
  assign out_last  = w_out_valid && (r_fidx[r_rptr] == LAST_IDX);
  assign busy      = (r_state != IDLE);
  assign error     = (r_state == ERR);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and core command decode
  always_comb begin
    w_next         = r_state;
    core_operation = 2'b00;
    core_addr      = '0;
    core_x         = '0;
    case (r_state)
      IDLE, LOAD: begin
        if (w_beat) begin
          core_operation = 2'b01;
          core_addr      = {24'd0, r_load_cnt};
          core_x         = in_data;
          w_next         = (r_load_cnt == LAST_IDX) ? PROC : LOAD;
        end
      end
      PROC: begin
        core_operation = 2'b10;
        if (core_done)                w_next = READ;
        else if (r_to_cnt == TO_LAST) w_next = ERR;
      end
      READ: begin
        core_operation = 2'b11;
        core_addr      = {24'd0, r_rd_cnt};
        if (w_last_pop) w_next = IDLE;
      end
      ERR:     w_next = ERR;
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  // Frame counters, read tracking and FIFO pointers
  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      r_load_cnt <= '0;
      r_rd_cnt   <= '0;
      r_cap_idx  <= '0;
      r_rd_done  <= 1'b0;
      r_inflight <= 1'b0;
      r_to_cnt   <= '0;
      r_occ      <= '0;
      r_rptr     <= 1'b0;
      r_wptr     <= 1'b0;
    end else begin
      if (w_beat) r_load_cnt <= (r_load_cnt == LAST_IDX) ? 8'd0 : r_load_cnt + 8'd1;
      r_to_cnt   <= ((r_state == PROC) && (w_next == PROC)) ? r_to_cnt + 32'd1 : 32'd0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_cap_idx <= r_rd_cnt;
        if (r_rd_cnt == LAST_IDX) r_rd_done <= 1'b1;
        else                      r_rd_cnt  <= r_rd_cnt + 8'd1;
      end
      if (w_last_pop) begin
        r_rd_cnt  <= '0;
        r_rd_done <= 1'b0;
      end
      r_occ <= w_pend;
      if (r_inflight) r_wptr <= ~r_wptr;
      if (w_pop)      r_rptr <= ~r_rptr;
    end
  end

  // FIFO storage: capture core result one cycle after its read was issued
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fre[r_wptr]  <= core_y_re;
      r_fim[r_wptr]  <= core_y_im;
      r_fidx[r_wptr] <= r_cap_idx;
    end
  end

`ifdef FOURIER_SEQ_PERF_EN
  logic [31:0] r_perf_cnt;
  logic [31:0] r_perf_cycles;

  // Frame latency: restart on first beat, latch at last result pop, saturate
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_cnt    <= '0;
      r_perf_cycles <= '0;
    end else begin
      if (w_beat && (r_state == IDLE)) r_perf_cnt <= '0;
      else if (r_perf_cnt != 32'hFFFF_FFFF) r_perf_cnt <= r_perf_cnt + 32'd1;
      if (w_last_pop)
        r_perf_cycles <= (r_perf_cnt == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : r_perf_cnt + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_fourier_seq_ctrl.sv
// Testbench for fourier_seq_ctrl with a behavioural DFT-core stub:
// y_re = 3*addr, y_im = addr+100 (registered), done 5 cycles into PROC.
module tb_fourier_seq_ctrl;

  localparam int N = 10;

  typedef struct {
    logic [31:0] x;
    logic [31:0] re;
    logic [31:0] im;
    logic        last;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_re;
  logic [31:0] out_im;
  logic [7:0]  out_index;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic [1:0]  core_operation;
  logic [31:0] core_addr;
  logic [31:0] core_x;
  logic [31:0] core_y_re = '0;
  logic [31:0] core_y_im = '0;
  logic        core_done;
  logic        busy;
  logic        error;
  logic [31:0] perf_cycles;

  logic        stub_done_en = 1'b1;
  int          stub_pc = 0;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  vec_t        vec [N];

  fourier_seq_ctrl #(.N(N), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last), .out_ready(out_ready),
    .core_operation(core_operation), .core_addr(core_addr), .core_x(core_x),
    .core_y_re(core_y_re), .core_y_im(core_y_im), .core_done(core_done),
    .busy(busy), .error(error), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core stub
  always @(posedge clk) begin
    core_y_re <= 32'd3 * core_addr;
    core_y_im <= core_addr + 32'd100;
    if (core_operation == 2'b10) stub_pc <= stub_pc + 1;
    else                         stub_pc <= 0;
  end
  assign core_done = stub_done_en && (stub_pc >= 5);

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, got, got, exp, exp, cyc);
  endtask

  task automatic do_reset();
    reset = 1'b0; abort = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_op", core_operation, 0);
    check("rst_addr", core_addr, 0);
    check("rst_x", core_x, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_perf", perf_cycles, 0);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic send(input int nb, input bit gap, output int bcyc);
    bcyc = 0;
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = vec[i].x;
      @(negedge clk);
      if (i == 0) bcyc = cyc;
      check("ld_ready", in_ready, 1);
      check("ld_op", core_operation, 2'b01);
      check("ld_addr", core_addr, i);
      check("ld_x", core_x, vec[i].x);
      if (gap && (i < nb - 1)) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("gap_op", core_operation, 2'b00);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic collect(input bit bp, output int first_pop, output int last_pop);
    int k = 0, n = 0, stall_left = 0, seen_read = -1, seen_valid = -1, maxout = 0;
    logic held = 1'b0;
    logic [31:0] hold_re = '0, hold_im = '0;
    first_pop = -1; last_pop = -1;
    while (k < N && n < 300) begin
      @(posedge clk); #1;
      if (!bp)                 out_ready = 1'b1;
      else if (seen_valid < 0) out_ready = 1'b0;
      else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else                     out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (core_operation == 2'b11) begin
        if (seen_read < 0) seen_read = n;
        if (int'(core_addr) - k > maxout) maxout = int'(core_addr) - k;
      end
      if (out_valid) begin
        if (seen_valid < 0) begin seen_valid = n; stall_left = 5; end
        if (held) begin
          check("stall_re", out_re, hold_re);
          check("stall_im", out_im, hold_im);
        end
        if (out_ready) begin
          check("res_index", out_index, k);
          check("res_re", out_re, vec[k].re);
          check("res_im", out_im, vec[k].im);
          check("res_last", out_last, vec[k].last);
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1; hold_re = out_re; hold_im = out_im;
        end
      end else if (held) begin
        check("no_retract", out_valid, 1);
        held = 1'b0;
      end
    end
    check("all_results", k, N);
    check("first_valid_lat", seen_valid - seen_read, 2);
    check("outstanding_le2", maxout <= 2, 1);
    if (!bp) check("throughput", last_pop - first_pop, N - 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_valid", out_valid, 0);
  endtask

  initial begin
    int bc, fp, lp, n;
    logic ok;
    vec[0] = '{32'd0, 32'd0,  32'd100, 1'b0};
    vec[1] = '{32'd1, 32'd3,  32'd101, 1'b0};
    vec[2] = '{32'd2, 32'd6,  32'd102, 1'b0};
    vec[3] = '{32'd3, 32'd9,  32'd103, 1'b0};
    vec[4] = '{32'd4, 32'd12, 32'd104, 1'b0};
    vec[5] = '{32'd5, 32'd15, 32'd105, 1'b0};
    vec[6] = '{32'd6, 32'd18, 32'd106, 1'b0};
    vec[7] = '{32'd7, 32'd21, 32'd107, 1'b0};
    vec[8] = '{32'd8, 32'd24, 32'd108, 1'b0};
    vec[9] = '{32'd9, 32'd27, 32'd109, 1'b1};

    // Nominal frame
    do_reset();
    send(N, 1'b0, bc);
    @(negedge clk);
    check("proc_op", core_operation, 2'b10);
    check("proc_in_ready", in_ready, 0);
    check("proc_busy", busy, 1);
    collect(1'b0, fp, lp);
`ifdef FOURIER_SEQ_PERF_EN
    check("perf_cycles", perf_cycles, lp - bc);
`else
    check("perf_off", perf_cycles, 0);
`endif

    // Input gaps
    send(N, 1'b1, bc);
    collect(1'b0, fp, lp);

    // Output backpressure
    send(N, 1'b0, bc);
    collect(1'b1, fp, lp);

    // Timeout into ERR, then abort out of it
    stub_done_en = 1'b0;
    send(N, 1'b0, bc);
    ok = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (core_operation != 2'b10 || error != 1'b0) ok = 1'b0;
    end
    check("to_proc_16", ok, 1);
    in_valid = 1'b1; in_data = 32'd7;
    @(negedge clk);
    check("err_flag", error, 1);
    check("err_in_ready", in_ready, 0);
    check("err_op", core_operation, 2'b00);
    check("err_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_err_clr", error, 0);
    check("abort_idle", busy, 0);
    stub_done_en = 1'b1;

    // Reset mid-frame, then a full frame
    send(4, 1'b0, bc);
    do_reset();
    send(N, 1'b0, bc);
    collect(1'b0, fp, lp);

    // Abort during READ
    send(N, 1'b0, bc);
    n = 0;
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("abort_rd_wait", out_valid, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid || busy) ok = 1'b0;
    end
    check("abort_flush", ok, 1);
    send(N, 1'b0, bc);
    collect(1'b0, fp, lp);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
